bus_cycle_master: RTL and testbench
===================================

# bus_cycle_master

Bus-side cycle generator that sits directly upstream of the addressable I/O/memory devices on the 20-bit address / 8-bit data bus. It accepts read/write requests from the core over a valid/ready handshake and sequences each one into a fixed four-state bus cycle (T1–T4): it drives CS, ALE, active-low RD/WR, Address and the shared tri-state Data bus. It then returns read data, or write completion, as a one-cycle response pulse.

## Interface
- ADDR_W, 20, address width
- DATA_W, 8, data width
- FIFO_DEPTH, 4, request FIFO entries; power of two ≥2; used only with BUSM_REQ_FIFO_EN
- CLK  in  1  clock; all logic on posedge
- RESET  in  1  reset, synchronous, active-high
- REQ_VALID  in  1  request present
- REQ_READY  out  1  request accepted on posedge when REQ_VALID && REQ_READY
- REQ_WRITE  in  1  1 = write, 0 = read
- REQ_ADDR  in  ADDR_W  target address
- REQ_WDATA  in  DATA_W  write data
- RSP_VALID  out  1  one-cycle completion pulse
- RSP_WRITE  out  1  echo of completed request type; valid with RSP_VALID
- RSP_RDATA  out  DATA_W  read data; holds last captured value
- CS  out  1  device select, active-high
- ALE  out  1  address latch enable, active-high
- RD  out  1  read strobe, active-low
- WR  out  1  write strobe, active-low
- Address  out  ADDR_W  bus address
- Data  inout  DATA_W  shared tri-state data bus

## Operation
- FSM states: IDLE, T1, T2, T3, T4. Transitions:
  - IDLE→T1 when a request is taken.
  - T1→T2→T3→T4 unconditionally.
  - T4→T1 if a request is taken in T4, else T4→IDLE.
- The accepted request is registered into cur_write, cur_addr and cur_wdata. These hold until the next accept.
- T1: CS=1, ALE=1, Address=cur_addr, RD=WR=1, Data released.
- T2: CS=1, ALE=0, Address held. Read: RD=0. Write: WR=0 and Data driven with cur_wdata.
- T3: same strobes as T2, Address held. Read: Data sampled into RSP_RDATA on the posedge ending T3. Write: Data still driven; the device writes on that edge.
- T4: CS=0, RD=WR=1, Data released, Address held. RSP_VALID=1 and RSP_WRITE=cur_write.
- Data is driven only in T2/T3 of a write. It is 'z at all other times.
- Never RD=0 and WR=0 together. ALE high only in T1.
- Write completions leave RSP_RDATA unchanged.

## Timing
- Reset values (next edge with RESET=1):
  - state IDLE; CS=0, ALE=0, RD=1, WR=1, Address=0, Data='z
  - RSP_VALID=0, RSP_WRITE=0, RSP_RDATA=0, REQ_READY per mode
- Reset mid-cycle aborts the cycle: strobes inactive next cycle, no RSP_VALID, FIFO emptied.
- Bus cycle length is exactly 4 clocks. Back-to-back throughput is one request per 4 clocks, with T4 followed directly by T1.
- Without FIFO:
  - REQ_READY = (state==IDLE || state==T4).
  - Accept edge E → T1 in cycle E+1 → RSP_VALID in cycle E+4.
- REQ_ADDR, REQ_WRITE and REQ_WDATA are don't-care when not accepted.

## Configuration
- BUSM_REQ_FIFO_EN defined: a FIFO_DEPTH-entry request FIFO sits between the handshake and the FSM.
  - REQ_READY = !full, independent of FSM state.
  - Pop occurs when state is IDLE or T4 and the FIFO is non-empty. Popped entries are registered, with no fall-through.
  - Latency with an empty FIFO: accept edge E → pop at E+1 → T1 at E+2 → RSP_VALID at E+5.
  - Push and pop in the same cycle leave the count unchanged. No push occurs when full. Pointers wrap modulo FIFO_DEPTH.
  - Requests complete in acceptance order.
- BUSM_REQ_FIFO_EN undefined: no FIFO storage; behaviour as in Timing.

## Test plan
- Reset: hold RESET 2 cycles mid-T2 of a write → next cycle CS=0, ALE=0, RD=1, WR=1, Data='z; no RSP_VALID; REQ_READY=1 after reset.
- Write then read: write 0x12345←0xA5, then read 0x12345 → read cycle shows ALE only in T1 and RD=0 in T2/T3; RSP_VALID with RSP_RDATA=0xA5, RSP_WRITE=0.
- Back-to-back: REQ_VALID held with 3 writes to 0x00010–0x00012 → T4 followed directly by T1, exactly 12 cycles of bus activity, 3 RSP_VALID pulses 4 cycles apart.
- Bus contention check: during all reads Data is driven only by the device (master 'z), and never RD=0 && WR=0.
- FIFO (BUSM_REQ_FIFO_EN, FIFO_DEPTH=4): burst of 6 requests on consecutive cycles → REQ_READY drops when 4 entries are queued, and all 6 complete in order.
- Idle: no requests for 20 cycles → state IDLE, CS=0, RD=WR=1, no RSP_VALID.

Source files
------------

// File: rtl/bus_cycle_master.sv
// bus_cycle_master: sequences core read/write requests into fixed four-clock T1-T4 bus cycles.
// Optional request FIFO between handshake and FSM is enabled by defining BUSM_REQ_FIFO_EN.
module bus_cycle_master #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WRITE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RSP_VALID,
  output logic              RSP_WRITE,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              CS,
  output logic              ALE,
  output logic              RD,
  output logic              WR,
  output logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] Data
);

  // IDLE no cycle | T1 address + ALE | T2,T3 strobe active | T4 response pulse
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_T3   = 3'd3;
  localparam logic [2:0] S_T4   = 3'd4;

  logic [2:0]        r_state;
  logic              r_cur_write;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [DATA_W-1:0] r_cur_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_free;
  logic              w_load;
  logic              w_ld_write;
  logic [ADDR_W-1:0] w_ld_addr;
  logic [DATA_W-1:0] w_ld_wdata;
  logic              w_strobe;
  logic              w_drive;

  assign w_free = (r_state == S_IDLE) || (r_state == S_T4);

`ifdef BUSM_REQ_FIFO_EN
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] LP_DEPTH = (PTR_W+1)'(FIFO_DEPTH);

  logic [ADDR_W+DATA_W:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic [PTR_W:0]         r_count;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;

  assign w_full    = (r_count == LP_DEPTH);
  assign w_push    = REQ_VALID && !w_full;
  assign w_pop     = w_free && (r_count != '0);
  assign REQ_READY = !w_full;
  assign w_load    = w_pop;
  assign {w_ld_write, w_ld_addr, w_ld_wdata} = r_fifo[r_rptr];

  // Depth is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge CLK) begin
    if (w_push) r_fifo[r_wptr] <= {REQ_WRITE, REQ_ADDR, REQ_WDATA};
    if (RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  assign REQ_READY  = w_free;
  assign w_load     = REQ_VALID && w_free;
  assign w_ld_write = REQ_WRITE;
  assign w_ld_addr  = REQ_ADDR;
  assign w_ld_wdata = REQ_WDATA;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_cur_write <= 1'b0;
      r_cur_addr  <= '0;
      r_cur_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= w_load ? S_T1 : S_IDLE;
        S_T1:    r_state <= S_T2;
        S_T2:    r_state <= S_T3;
        S_T3:    r_state <= S_T4;
        S_T4:    r_state <= w_load ? S_T1 : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_load) begin
        r_cur_write <= w_ld_write;
        r_cur_addr  <= w_ld_addr;
        r_cur_wdata <= w_ld_wdata;
      end
      if ((r_state == S_T3) && !r_cur_write) r_rdata <= Data;
    end
  end

  assign w_strobe  = (r_state == S_T2) || (r_state == S_T3);
  assign w_drive   = w_strobe && r_cur_write;

  assign CS        = (r_state == S_T1) || w_strobe;
  assign ALE       = (r_state == S_T1);
  assign RD        = !(w_strobe && !r_cur_write);
  assign WR        = !w_drive;
  assign Address   = r_cur_addr;
  assign Data      = w_drive ? r_cur_wdata : {DATA_W{1'bz}};
  assign RSP_VALID = (r_state == S_T4);
  assign RSP_WRITE = (r_state == S_T4) && r_cur_write;
  assign RSP_RDATA = r_rdata;

endmodule

// File: tb/tb_bus_cycle_master.sv
// Bench for bus_cycle_master: transaction-timeline model with per-cycle compare plus directed checks.
// Define BUSM_REQ_FIFO_EN to exercise the request FIFO build.
module tb_bus_cycle_master;
  localparam int AW    = 20;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
`ifdef BUSM_REQ_FIFO_EN
  localparam int LAT   = 1;
  localparam bit FIFO  = 1'b1;
`else
  localparam int LAT   = 0;
  localparam bit FIFO  = 1'b0;
`endif

  typedef struct { logic w; logic [AW-1:0] a; logic [DW-1:0] d; logic [DW-1:0] rd; int e; int s; } txn_t;
  typedef struct { int n; logic w; logic [DW-1:0] rd; } rsp_t;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          REQ_VALID = 1'b0;
  logic          REQ_WRITE = 1'b0;
  logic [AW-1:0] REQ_ADDR = '0;
  logic [DW-1:0] REQ_WDATA = '0;
  logic          REQ_READY, RSP_VALID, RSP_WRITE, CS, ALE, RD, WR;
  logic [DW-1:0] RSP_RDATA;
  logic [AW-1:0] Address;
  wire  [DW-1:0] Data;

  logic [DW-1:0] dmem [256] = '{default: 8'h00};
  logic [DW-1:0] mmem [256] = '{default: 8'h00};

  int   tests = 0;
  int   fails = 0;
  int   n = 0;
  bit   armed = 1'b0;
  bit   acc_now = 1'b0;
  txn_t q[$];
  rsp_t rlog[$];
  int   act_cnt = 0;
  int   rdy_seen = 0;

  int            e_phase = -1;
  logic          e_cs = 0, e_ale = 0, e_rd = 1, e_wr = 1, e_rv = 0, e_rw = 0, e_ready = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0, e_rdata = '0;

  bus_cycle_master #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_WRITE(RSP_WRITE), .RSP_RDATA(RSP_RDATA),
    .CS(CS), .ALE(ALE), .RD(RD), .WR(WR), .Address(Address), .Data(Data)
  );

  always #5 CLK = ~CLK;

  // Device: drives read data while RD is low, holds the bus at 0 otherwise unless the master writes
  assign Data = WR ? (RD ? 8'h00 : dmem[Address[7:0]]) : 8'hzz;

  initial forever begin
    @(posedge CLK);
    if (!WR) dmem[Address[7:0]] = Data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, n);
    end
  endtask

  // Model: each request occupies edges s..s+3 (T1..T4), s = max(accept + LAT, previous s + 4)
  initial begin
    txn_t t, ct;
    int   cnt;
    bit   strobe;
    forever begin
      @(posedge CLK);
      n = n + 1;
      acc_now = 1'b0;
      if (RESET) begin
        q.delete();
        e_rdata = '0;
        e_addr  = '0;
        armed   = 1'b1;
      end else if (armed) begin
        if (REQ_VALID && e_ready) begin
          t.w = REQ_WRITE; t.a = REQ_ADDR; t.d = REQ_WDATA; t.e = n;
          t.s = n + LAT;
          if (q.size() > 0 && q[q.size()-1].s + 4 > t.s) t.s = q[q.size()-1].s + 4;
          t.rd = mmem[REQ_ADDR[7:0]];
          if (REQ_WRITE) mmem[REQ_ADDR[7:0]] = REQ_WDATA;
          q.push_back(t);
          acc_now = 1'b1;
        end
        while (q.size() > 0 && n > q[0].s + 3 && q.size() > 1) q.delete(0);
        if (q.size() == 1 && n > q[0].s + 3) q.delete(0);
      end
      e_phase = -1;
      cnt = 0;
      ct = '{default: 0};
      foreach (q[i]) begin
        if (n >= q[i].s && n <= q[i].s + 3) begin
          e_phase = n - q[i].s;
          ct = q[i];
        end
        if (q[i].e <= n && n < q[i].s) cnt++;
      end
      if (e_phase == 0) e_addr = ct.a;
      if (e_phase == 3 && !ct.w) e_rdata = ct.rd;
      strobe  = (e_phase == 1) || (e_phase == 2);
      e_cs    = (e_phase >= 0) && (e_phase <= 2);
      e_ale   = (e_phase == 0);
      e_rd    = !(strobe && !ct.w);
      e_wr    = !(strobe && ct.w);
      e_rv    = (e_phase == 3);
      e_rw    = (e_phase == 3) && ct.w;
      e_data  = strobe ? (ct.w ? ct.d : ct.rd) : 8'h00;
      e_ready = FIFO ? (cnt < DEPTH) : !((e_phase >= 0) && (e_phase <= 2));
    end
  end

  initial forever begin
    @(negedge CLK);
    if (armed) begin
      chk("cs", 32'(CS), 32'(e_cs));
      chk("ale", 32'(ALE), 32'(e_ale));
      chk("rd_n", 32'(RD), 32'(e_rd));
      chk("wr_n", 32'(WR), 32'(e_wr));
      chk("rd_wr_exclusive", 32'(RD | WR), 32'(1));
      chk("address", 32'(Address), 32'(e_addr));
      chk("data_bus", 32'(Data), 32'(e_data));
      chk("rsp_valid", 32'(RSP_VALID), 32'(e_rv));
      chk("rsp_write", 32'(RSP_WRITE), 32'(e_rw));
      chk("rsp_rdata", 32'(RSP_RDATA), 32'(e_rdata));
      chk("req_ready", 32'(REQ_READY), 32'(e_ready));
    end
  end

  initial forever begin
    @(negedge CLK);
    if (armed) begin
      if (RSP_VALID) rlog.push_back('{n: n, w: RSP_WRITE, rd: RSP_RDATA});
      if (CS || RSP_VALID) act_cnt++;
    end
  end

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k;
    @(negedge CLK);
    rdy_seen  = int'(REQ_READY);
    REQ_VALID = 1'b1; REQ_WRITE = w; REQ_ADDR = a; REQ_WDATA = d;
    k = 0;
    do begin
      @(posedge CLK); #1;
      k++;
    end while (!acc_now && k < 50);
    REQ_VALID = 1'b0;
    if (!acc_now) begin
      tests++; fails++;
      $display("FAIL accept_timeout: request to %0h not taken after %0d cycles", a, k);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while ((q.size() != 0 || e_phase != -1) && k < 80);
    if (q.size() != 0 || e_phase != -1) begin
      tests++; fails++;
      $display("FAIL idle_timeout: %0d requests still pending", q.size());
    end
  endtask

  initial begin
    int   k;
    int   r5, r6;
    logic exp_w [6];
    exp_w = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    chk("post_reset_ready", 32'(REQ_READY), 32'(1));
    chk("post_reset_rdata", 32'(RSP_RDATA), 32'(0));
    chk("post_reset_addr", 32'(Address), 32'(0));

    rlog.delete();
    send(1'b1, 20'h12345, 8'hA5);
    send(1'b0, 20'h12345, 8'h00);
    wait_idle();
    chk("wr_rd_rsp_count", 32'(rlog.size()), 32'(2));
    if (rlog.size() == 2) begin
      chk("wr_rsp_is_write", 32'(rlog[0].w), 32'(1));
      chk("rd_rsp_is_read", 32'(rlog[1].w), 32'(0));
      chk("rd_rsp_data", 32'(rlog[1].rd), 32'(8'hA5));
      chk("wr_rd_rsp_gap", 32'(rlog[1].n - rlog[0].n), 32'(4));
    end

    rlog.delete();
    act_cnt = 0;
    send(1'b1, 20'h00010, 8'h11);
    send(1'b1, 20'h00011, 8'h22);
    send(1'b1, 20'h00012, 8'h33);
    wait_idle();
    chk("b2b_rsp_count", 32'(rlog.size()), 32'(3));
    if (rlog.size() == 3) begin
      chk("b2b_gap_1", 32'(rlog[1].n - rlog[0].n), 32'(4));
      chk("b2b_gap_2", 32'(rlog[2].n - rlog[1].n), 32'(4));
    end
    chk("b2b_bus_cycles", 32'(act_cnt), 32'(12));
    chk("write_keeps_rdata", 32'(RSP_RDATA), 32'(8'hA5));
    send(1'b0, 20'h00011, 8'h00);
    wait_idle();
    chk("readback_0011", 32'(RSP_RDATA), 32'(8'h22));

    rlog.delete();
    send(1'b1, 20'h00020, 8'h3C);
    k = 0;
    while (e_phase != 1 && k < 10) begin
      @(negedge CLK);
      k++;
    end
    if (e_phase != 1) begin
      tests++; fails++;
      $display("FAIL abort_reach_t2: phase %0d after %0d cycles", e_phase, k);
    end
    RESET = 1'b1;
    @(negedge CLK);
    chk("abort_cs", 32'(CS), 32'(0));
    chk("abort_ale", 32'(ALE), 32'(0));
    chk("abort_rd", 32'(RD), 32'(1));
    chk("abort_wr", 32'(WR), 32'(1));
    chk("abort_data_released", 32'(Data), 32'(0));
    @(negedge CLK);
    RESET = 1'b0;
    repeat (6) @(negedge CLK);
    chk("abort_no_rsp", 32'(rlog.size()), 32'(0));
    chk("abort_ready", 32'(REQ_READY), 32'(1));

    rlog.delete();
    send(1'b1, 20'h00030, 8'h71);
    send(1'b1, 20'h00031, 8'h72);
    send(1'b1, 20'h00032, 8'h73);
    send(1'b0, 20'h00030, 8'h00);
    send(1'b0, 20'h00031, 8'h00);
    r5 = rdy_seen;
    send(1'b0, 20'h00032, 8'h00);
    r6 = rdy_seen;
    wait_idle();
    chk("burst_ready_before_5th", 32'(r5), FIFO ? 32'(1) : 32'(0));
    chk("burst_ready_before_6th", 32'(r6), 32'(0));
    chk("burst_rsp_count", 32'(rlog.size()), 32'(6));
    if (rlog.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("burst_order_type", 32'(rlog[i].w), 32'(exp_w[i]));
      chk("burst_rd0", 32'(rlog[3].rd), 32'(8'h71));
      chk("burst_rd1", 32'(rlog[4].rd), 32'(8'h72));
      chk("burst_rd2", 32'(rlog[5].rd), 32'(8'h73));
    end

    rlog.delete();
    repeat (20) @(negedge CLK);
    chk("idle_no_rsp", 32'(rlog.size()), 32'(0));
    chk("idle_cs", 32'(CS), 32'(0));
    chk("idle_rd", 32'(RD), 32'(1));
    chk("idle_wr", 32'(WR), 32'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete at time %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
